// File: rtl/ttlc_icu.sv
// ttlc_icu: single-bit MC14500B-style control unit driving the TTLC I/O bus.
// Fetches 12-bit instructions over a req/ack handshake and keeps a small JMP/RTN return stack.
module ttlc_icu #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        prog_rd,
  output logic [7:0]  prog_addr,
  input  logic        prog_ack,
  input  logic [11:0] prog_data,
  output logic [7:0]  io_addr,
  output logic        io_write,
  output logic        io_wdata,
  input  logic        io_rdata,
  output logic        rr,
  output logic        flag_o,
  output logic        flag_f,
  output logic        stk_err
);

  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;
  typedef enum logic [3:0] {
    OpNopo, OpLd, OpLdc, OpAnd, OpAndc, OpOr, OpOrc, OpXnor,
    OpSto, OpStoc, OpIen, OpOen, OpJmp, OpRtn, OpSkz, OpNopf
  } op_e;

  // Async assert, sync deassert: internal logic leaves reset two edges after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [11:0]      ir_q, ir_d;
  logic             ir_skip_q, ir_skip_d;
  logic             skip_q, skip_d;
  logic             rr_q, rr_d;
  logic             ien_q, ien_d;
  logic             oen_q, oen_d;
  logic             stk_err_q, stk_err_d;
  logic [SpW-1:0]   sp_q, sp_d;
  logic [7:0]       stack_q [STACK_DEPTH];
  logic [7:0]       stack_d [STACK_DEPTH];

  op_e        op;
  logic [7:0] operand;
  logic [7:0] pc_inc;
  logic       d;
  logic       exec_en;
  logic       stk_full;
  logic       stk_empty;

  assign op        = op_e'(ir_q[11:8]);
  assign operand   = ir_q[7:0];
  assign pc_inc    = pc_q + 8'd1;
  assign d         = io_rdata & ien_q;
  assign exec_en   = (state_q == StExec) && !ir_skip_q;
  assign stk_full  = (sp_q == SpW'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StFetch;
      StFetch: if (prog_ack) state_d = StExec;
      StExec:  state_d = run ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pc_q      <= '0;
      ir_q      <= '0;
      ir_skip_q <= 1'b0;
      skip_q    <= 1'b0;
      rr_q      <= 1'b0;
      ien_q     <= 1'b0;
      oen_q     <= 1'b0;
      stk_err_q <= 1'b0;
      sp_q      <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ir_skip_q <= ir_skip_d;
      skip_q    <= skip_d;
      rr_q      <= rr_d;
      ien_q     <= ien_d;
      oen_q     <= oen_d;
      stk_err_q <= stk_err_d;
      sp_q      <= sp_d;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= stack_d[i];
    end
  end

  // Datapath next-state; the stack is a shift register with the top at entry 0
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    ir_skip_d = ir_skip_q;
    skip_d    = skip_q;
    rr_d      = rr_q;
    ien_d     = ien_q;
    oen_d     = oen_q;
    stk_err_d = stk_err_q;
    sp_d      = sp_q;
    for (int i = 0; i < int'(STACK_DEPTH); i++) stack_d[i] = stack_q[i];

    if (state_q == StFetch && prog_ack) begin
      ir_d      = prog_data;
      ir_skip_d = skip_q;
      skip_d    = 1'b0;
    end

    if (state_q == StExec) begin
      pc_d = pc_inc;
      if (!ir_skip_q) begin
        unique case (op)
          OpLd:   rr_d  = d;
          OpLdc:  rr_d  = ~d;
          OpAnd:  rr_d  = rr_q & d;
          OpAndc: rr_d  = rr_q & ~d;
          OpOr:   rr_d  = rr_q | d;
          OpOrc:  rr_d  = rr_q | ~d;
          OpXnor: rr_d  = ~(rr_q ^ d);
          OpIen:  ien_d = io_rdata;
          OpOen:  oen_d = io_rdata;
          OpJmp: begin
            pc_d = operand;
            if (stk_full) begin
              stk_err_d = 1'b1;
            end else begin
              stack_d[0] = pc_inc;
              for (int i = 1; i < int'(STACK_DEPTH); i++) stack_d[i] = stack_q[i-1];
              sp_d = sp_q + SpW'(1);
            end
          end
          OpRtn: begin
            if (stk_empty) begin
              stk_err_d = 1'b1;
            end else begin
              pc_d   = stack_q[0];
              skip_d = 1'b1;
              for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) stack_d[i] = stack_q[i+1];
              sp_d = sp_q - SpW'(1);
            end
          end
          OpSkz:  if (!rr_q) skip_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Outputs; strobes are qualified by a live EXEC so reset kills them immediately
  always_comb begin
    prog_rd   = (state_q == StFetch);
    prog_addr = pc_q;
    io_addr   = operand;
    io_write  = exec_en && oen_q && (op == OpSto || op == OpStoc);
    io_wdata  = io_write && ((op == OpStoc) ? ~rr_q : rr_q);
    flag_o    = exec_en && (op == OpNopo);
    flag_f    = exec_en && (op == OpNopf);
    rr        = rr_q;
    stk_err   = stk_err_q;
  end

endmodule
